// File: rtl/ascon_enc_seq_if.sv
// ascon_enc_seq_if: host/core handshake bundle for the ASCON encryption sequencer.
// The master side is the host that raises requests; the slave side is the sequencer.

interface ascon_enc_seq_if;
    logic       reqxSI;
    logic       abortxSI;
    logic       encryption_readyxSI;
    logic       core_rstxSO;
    logic       core_startxSO;
    logic       load_validxSO;
    logic [7:0] load_idxxSO;
    logic       ct_validxSO;
    logic       tag_validxSO;
    logic [7:0] out_idxxSO;
    logic       busyxSO;
    logic       donexSO;
    logic       errxSO;

    modport master (
        output reqxSI, abortxSI, encryption_readyxSI,
        input  core_rstxSO, core_startxSO, load_validxSO, load_idxxSO,
               ct_validxSO, tag_validxSO, out_idxxSO, busyxSO, donexSO, errxSO
    );

    modport slave (
        input  reqxSI, abortxSI, encryption_readyxSI,
        output core_rstxSO, core_startxSO, load_validxSO, load_idxxSO,
               ct_validxSO, tag_validxSO, out_idxxSO, busyxSO, donexSO, errxSO
    );
endinterface

// File: rtl/ascon_enc_seq.sv
// ascon_enc_seq: sequences one ASCON encryption on an external core:
// clear the core, stream NLD load beats, hold start until ready, then
// walk NOUT output beats (ciphertext bytes first Y/8, tag bytes first 16).
// Build option: define ASCON_SEQ_WATCHDOG_EN to bound the START wait to TMO
// cycles; on expiry the block parks in ERR with errxSO set until aborted.

module ascon_enc_seq #(
    parameter int K   = 128,
    parameter int L   = 80,
    parameter int Y   = 80,
    parameter int TMO = 4096
) (
    input  logic           clk,
    input  logic           rst,
    ascon_enc_seq_if.slave bus
);
    // Beat counts derived from the widest field that must be streamed.
    localparam int MAX_KL  = (K > L) ? K : L;
    localparam int MAX_KLY = (MAX_KL > Y) ? MAX_KL : Y;
    localparam int MAX_ALL = (MAX_KLY > 128) ? MAX_KLY : 128;
    localparam int NLD     = MAX_ALL / 8 + 1;
    localparam int NOUT    = ((Y > 128) ? Y : 128) / 8;
    localparam int YB      = Y / 8;
    localparam int TAGB    = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_LOAD,
        S_START,
        S_UNLOAD,
        S_DONE,
        S_ERR
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       abort_hit;

    logic       core_rst_q, core_rst_d;
    logic       core_start_q, core_start_d;
    logic       load_valid_q, load_valid_d;
    logic [7:0] load_idx_q, load_idx_d;
    logic       ct_valid_q, ct_valid_d;
    logic       tag_valid_q, tag_valid_d;
    logic [7:0] out_idx_q, out_idx_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

`ifdef ASCON_SEQ_WATCHDOG_EN
    localparam int WW = $clog2(TMO + 1);
    logic [WW-1:0] wd_q, wd_d;
    logic          err_q, err_d;
`endif

    // Next-state and beat-counter logic; abort overrides every transition.
    always_comb begin
        // NOTE: every signal gets its default before any branch, so no path leaves it unassigned and no latch is inferred.
        state_d   = state_q;
        cnt_d     = cnt_q;
        abort_hit = 1'b0;
`ifdef ASCON_SEQ_WATCHDOG_EN
        wd_d      = '0;
`endif
        if (bus.abortxSI && (state_q != S_IDLE)) begin
            state_d   = S_IDLE;
            cnt_d     = '0;
            abort_hit = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.reqxSI) begin
                        state_d = S_CLR;
                        cnt_d   = '0;
                    end
                end
                S_CLR: begin
                    state_d = S_LOAD;
                    cnt_d   = '0;
                end
                S_LOAD: begin
                    if (cnt_q == 8'(NLD - 1)) begin
                        state_d = S_START;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                S_START: begin
                    if (bus.encryption_readyxSI) begin
                        state_d = S_UNLOAD;
                        cnt_d   = '0;
`ifdef ASCON_SEQ_WATCHDOG_EN
                    end else if (wd_q == WW'(TMO - 1)) begin
                        state_d = S_ERR;
                    end else begin
                        wd_d = wd_q + 1'b1;
`endif
                    end
                end
                S_UNLOAD: begin
                    // Output beats follow a fixed schedule; ready is not consulted here.
                    if (cnt_q == 8'(NOUT - 1)) begin
                        state_d = S_DONE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                S_DONE:  state_d = S_IDLE;
                S_ERR:   state_d = S_ERR;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Output decode from the upcoming state so every output leaves a flop.
    always_comb begin
        core_rst_d   = (state_d == S_CLR) || abort_hit;
        core_start_d = (state_d == S_START);
        load_valid_d = (state_d == S_LOAD);
        load_idx_d   = load_valid_d ? cnt_d : 8'd0;
        ct_valid_d   = (state_d == S_UNLOAD) && (cnt_d < 8'(YB));
        tag_valid_d  = (state_d == S_UNLOAD) && (cnt_d < 8'(TAGB));
        out_idx_d    = (state_d == S_UNLOAD) ? cnt_d : 8'd0;
        busy_d       = (state_d != S_IDLE) && (state_d != S_ERR);
        done_d       = (state_d == S_DONE);
`ifdef ASCON_SEQ_WATCHDOG_EN
        err_d        = (state_d == S_ERR);
`endif
    end

    // State, counter and registered outputs; asynchronous reset abandons any run.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            core_rst_q   <= 1'b0;
            core_start_q <= 1'b0;
            load_valid_q <= 1'b0;
            load_idx_q   <= '0;
            ct_valid_q   <= 1'b0;
            tag_valid_q  <= 1'b0;
            out_idx_q    <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every flop sample the pre-edge values together.
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            core_rst_q   <= core_rst_d;
            core_start_q <= core_start_d;
            load_valid_q <= load_valid_d;
            load_idx_q   <= load_idx_d;
            ct_valid_q   <= ct_valid_d;
            tag_valid_q  <= tag_valid_d;
            out_idx_q    <= out_idx_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

`ifdef ASCON_SEQ_WATCHDOG_EN
    // Watchdog counter and sticky error flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            wd_q  <= wd_d;
            err_q <= err_d;
        end
    end

    assign bus.errxSO = err_q;
`else
    assign bus.errxSO = 1'b0;
`endif

    assign bus.core_rstxSO   = core_rst_q;
    assign bus.core_startxSO = core_start_q;
    assign bus.load_validxSO = load_valid_q;
    assign bus.load_idxxSO   = load_idx_q;
    assign bus.ct_validxSO   = ct_valid_q;
    assign bus.tag_validxSO  = tag_valid_q;
    assign bus.out_idxxSO    = out_idx_q;
    assign bus.busyxSO       = busy_q;
    assign bus.donexSO       = done_q;
endmodule

// File: tb/tb_ascon_enc_seq.sv
// tb_ascon_enc_seq: bench for ascon_enc_seq. Two instances: default
// parameters and K=128/L=160/Y=200. Expected outputs per cycle come from a
// timeline model: offset t from the accepted request maps onto the phases
// clear, load, start (length d+1), unload, done, idle.

module tb_ascon_enc_seq;
    localparam int TMO_TB = 16;

    typedef struct packed {
        logic       core_rst;
        logic       core_start;
        logic       load_valid;
        logic [7:0] load_idx;
        logic       ct_valid;
        logic       tag_valid;
        logic [7:0] out_idx;
        logic       busy;
        logic       done;
        logic       err;
    } obs_t;

    logic clk;
    logic rst;
    logic req, abort, ready;
    bit   sel;
    int   n_checks, n_errors;
    int   m_nld[2], m_nout[2], m_yb[2];

    ascon_enc_seq_if ifa ();
    ascon_enc_seq_if ifb ();

    assign ifa.reqxSI              = req & ~sel;
    assign ifa.abortxSI            = abort & ~sel;
    assign ifa.encryption_readyxSI = ready & ~sel;
    assign ifb.reqxSI              = req & sel;
    assign ifb.abortxSI            = abort & sel;
    assign ifb.encryption_readyxSI = ready & sel;

    ascon_enc_seq #(.TMO(TMO_TB)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
    ascon_enc_seq #(.K(128), .L(160), .Y(200), .TMO(TMO_TB)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int nld_of(input int k, input int l, input int y);
        int m;
        m = 128;
        if (k > m) m = k;
        if (l > m) m = l;
        if (y > m) m = y;
        return m / 8 + 1;
    endfunction

    function automatic obs_t get_obs(input bit w);
        obs_t o;
        if (w) begin
            o.core_rst = ifb.core_rstxSO;   o.core_start = ifb.core_startxSO;
            o.load_valid = ifb.load_validxSO; o.load_idx = ifb.load_idxxSO;
            o.ct_valid = ifb.ct_validxSO;   o.tag_valid = ifb.tag_validxSO;
            o.out_idx = ifb.out_idxxSO;     o.busy = ifb.busyxSO;
            o.done = ifb.donexSO;           o.err = ifb.errxSO;
        end else begin
            o.core_rst = ifa.core_rstxSO;   o.core_start = ifa.core_startxSO;
            o.load_valid = ifa.load_validxSO; o.load_idx = ifa.load_idxxSO;
            o.ct_valid = ifa.ct_validxSO;   o.tag_valid = ifa.tag_validxSO;
            o.out_idx = ifa.out_idxxSO;     o.busy = ifa.busyxSO;
            o.done = ifa.donexSO;           o.err = ifa.errxSO;
        end
        return o;
    endfunction

    // Expected outputs t cycles after the request is accepted, ready first seen in start cycle d.
    function automatic obs_t exp_at(input int t, input int d, input bit w);
        obs_t o;
        int nld, nout, yb, u;
        o    = '0;
        nld  = m_nld[w];
        nout = m_nout[w];
        yb   = m_yb[w];
`ifdef ASCON_SEQ_WATCHDOG_EN
        if (d >= TMO_TB && t >= nld + 1 + TMO_TB) begin
            o.err = 1'b1;
            return o;
        end
`endif
        if (t == 0) begin
            o.core_rst = 1'b1; o.busy = 1'b1;
        end else if (t <= nld) begin
            o.load_valid = 1'b1; o.load_idx = 8'(t - 1); o.busy = 1'b1;
        end else if (t <= nld + 1 + d) begin
            o.core_start = 1'b1; o.busy = 1'b1;
        end else if (t <= nld + 1 + d + nout) begin
            u = t - (nld + 2 + d);
            o.out_idx   = 8'(u);
            o.ct_valid  = (u < yb);
            o.tag_valid = (u < 16);
            o.busy      = 1'b1;
        end else if (t == nld + 2 + d + nout) begin
            o.done = 1'b1; o.busy = 1'b1;
        end
        return o;
    endfunction

    // One run from an idle DUT; optional abort or reset at offset abort_t / rst_t.
    task automatic run(input bit w, input int d, input int abort_t, input int rst_t, input bit hold);
        int   t_done, s;
        obs_t ab;
        string nm;
        t_done = m_nld[w] + 2 + d + m_nout[w];
        nm     = w ? "b" : "a";
        ab          = '0;
        ab.core_rst = 1'b1;
        sel   = w;
        req   = 1'b1;
        abort = 1'b0;
        ready = 1'($urandom);
        for (int t = 0; t <= t_done + 1; t++) begin
            @(negedge clk);
            check($sformatf("%s_d%0d_t%0d", nm, d, t), 32'(get_obs(w)), 32'(exp_at(t, d, w)));
            s = t - (m_nld[w] + 1);
            if (s >= 0 && s < d)  ready = 1'b0;
            else if (s == d)      ready = 1'b1;
            else                  ready = 1'($urandom);
            req = (t > t_done) ? hold : 1'($urandom);
            if (t == abort_t) begin
                abort = 1'b1;
                @(negedge clk);
                check($sformatf("%s_abort_t%0d", nm, t), 32'(get_obs(w)), 32'(ab));
                abort = 1'b0;
                req   = 1'b0;
                @(negedge clk);
                check($sformatf("%s_post_abort_t%0d", nm, t), 32'(get_obs(w)), 32'h0);
                return;
            end
            if (t == rst_t) begin
                #1 rst = 1'b1;
                #1 check($sformatf("%s_async_rst_t%0d", nm, t), 32'(get_obs(w)), 32'h0);
                @(negedge clk);
                check($sformatf("%s_in_rst_t%0d", nm, t), 32'(get_obs(w)), 32'h0);
                rst = 1'b0;
                req = 1'b0;
                return;
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "bench time limit");
    end

    initial begin
        int d;
        n_checks = 0;
        n_errors = 0;
        m_nld[0] = nld_of(128, 80, 80);   m_nout[0] = 16; m_yb[0] = 80 / 8;
        m_nld[1] = nld_of(128, 160, 200); m_nout[1] = 200 / 8; m_yb[1] = 200 / 8;
        sel   = 1'b0;
        rst   = 1'b1;
        req   = 1'b1;
        abort = 1'b1;
        ready = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_a", 32'(get_obs(1'b0)), 32'h0);
        check("reset_b", 32'(get_obs(1'b1)), 32'h0);
        req   = 1'b0;
        abort = 1'b0;
        ready = 1'b0;
        rst   = 1'b0;
        @(negedge clk);
        check("idle_after_release", 32'(get_obs(1'b0)), 32'h0);

        // Basic run, ready in start cycle 5.
        run(1'b0, 5, -1, -1, 1'b0);
        // Back-to-back with request held through done.
        run(1'b0, $urandom_range(0, 12), -1, -1, 1'b1);
        run(1'b0, 3, -1, -1, 1'b0);
        // Abort at load beat 8, then in start and in unload.
        run(1'b0, 2, 9, -1, 1'b0);
        run(1'b0, 7, m_nld[0] + 3, -1, 1'b0);
        run(1'b0, 1, m_nld[0] + 3 + $urandom_range(1, 15), -1, 1'b0);
        // Reset during unload beat 4, then a clean run.
        run(1'b0, 4, -1, m_nld[0] + 2 + 4 + 4, 1'b0);
        run(1'b0, 0, -1, -1, 1'b0);
        // Ready in the last start cycle the watchdog would allow.
        run(1'b0, TMO_TB - 1, -1, -1, 1'b0);
`ifdef ASCON_SEQ_WATCHDOG_EN
        run(1'b0, 1000, m_nld[0] + 1 + TMO_TB + 4, -1, 1'b0);
`else
        run(1'b0, 40, -1, -1, 1'b0);
`endif
        // Wide-parameter instance.
        run(1'b1, 5, -1, -1, 1'b1);
        run(1'b1, $urandom_range(0, 12), -1, -1, 1'b0);
        run(1'b1, 2, m_nld[1] + 3 + 20, -1, 1'b0);
        run(1'b1, 0, -1, -1, 1'b0);
        // Random runs on the default instance.
        for (int i = 0; i < 4; i++) begin
            d = $urandom_range(0, TMO_TB - 1);
            run(1'b0, d, -1, -1, 1'($urandom));
        end
        @(negedge clk);
        req = 1'b0;
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
